// File: rtl/data_sync_pkg.sv
// data_sync_pkg
// Shared definitions for the data synchronizer transmit and receive sides:
// the transmitter state encoding and default sizing constants.
package data_sync_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        GAP  = 2'b10
    } state_e;

    localparam int DEFAULT_BUS_WIDTH  = 8;
    localparam int DEFAULT_NUM_STAGES = 2;

endpackage

// File: rtl/data_sync_tx_if.sv
// data_sync_tx_if
// Bundles the word-input handshake and the crossing bus of data_sync_tx.
//   in_data/in_valid/in_ready : source-side valid/ready word input
//   unsync_bus/bus_enable     : quasi-static bus and level enable to receiver
//   busy                      : transmitter not idle
// master = producer/observer side, slave = data_sync_tx.
interface data_sync_tx_if #(
    parameter int BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] unsync_bus;
    logic                 bus_enable;
    logic                 busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, unsync_bus, bus_enable, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, unsync_bus, bus_enable, busy
    );
endinterface

// File: rtl/bit_sync.sv
// bit_sync
// Single-bit multi-flop synchronizer chain.
//   CLK : destination clock
//   RST : synchronous active-high reset, clears the chain to 0
//   d   : asynchronous input bit
//   q   : synchronized output (last stage)
module bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);
    logic [NUM_STAGES-1:0] sync_q;
    logic [NUM_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[NUM_STAGES-2:0], d};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[NUM_STAGES-1];
endmodule

// File: rtl/data_sync_tx.sv
// data_sync_tx
// Source-domain transmitter for the multi-flop data synchronizer. Accepts a
// word, raises bus_enable for HOLD_CYCLES with the word on unsync_bus, then
// keeps the bus frozen with the enable low for GAP_CYCLES before accepting
// the next word.
//   CLK            : source clock
//   RST            : synchronous active-high reset
//   bus (slave)    : in_data/in_valid/in_ready, unsync_bus, bus_enable, busy
//   bus_ack        : receiver acknowledge (only with DATA_SYNC_TX_ACK_EN)
// Optional feature macro: DATA_SYNC_TX_ACK_EN adds a four-phase handshake in
// which the hold/gap counters become minimum times and the synchronized
// bus_ack gates the HOLD->GAP and GAP->IDLE transitions.
//
// state | meaning
// IDLE  | ready for a word, bus holds the last word, enable low
// HOLD  | enable high, word stable on bus
// GAP   | enable low, word still stable so the receiver sees a clean fall
module data_sync_tx
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH   = DEFAULT_BUS_WIDTH,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_WIDTH   = 4
) (
    input  logic          CLK,
    input  logic          RST,
`ifdef DATA_SYNC_TX_ACK_EN
    input  logic          bus_ack,
`endif
    data_sync_tx_if.slave bus
);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "data_sync_tx: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $fatal(1, "data_sync_tx: GAP_CYCLES must be >= 1");
    end
    if (((1 << CNT_WIDTH) < HOLD_CYCLES) || ((1 << CNT_WIDTH) < GAP_CYCLES)) begin : g_bad_cnt
        $fatal(1, "data_sync_tx: CNT_WIDTH too small for HOLD_CYCLES/GAP_CYCLES");
    end

    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LOAD  = CNT_WIDTH'(GAP_CYCLES - 1);

    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 en_q, en_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic cnt_zero;
    logic hold_done;
    logic gap_done;

    assign cnt_zero = (cnt_q == '0);

`ifdef DATA_SYNC_TX_ACK_EN
    logic ack_s;

    bit_sync #(
        .NUM_STAGES(DEFAULT_NUM_STAGES)
    ) u_ack_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (bus_ack),
        .q   (ack_s)
    );

    // Counters are minimum times; the receiver's ack level finishes each phase.
    assign hold_done = cnt_zero && ack_s;
    assign gap_done  = cnt_zero && !ack_s;
`else
    assign hold_done = cnt_zero;
    assign gap_done  = cnt_zero;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        en_d    = en_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    en_d    = 1'b1;
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_done) begin
                    en_d    = 1'b0;
                    cnt_d   = GAP_LOAD;
                    state_d = GAP;
                end else if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_d = IDLE;
                end else if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            data_q  <= '0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
        end
    end

    // in_ready drops combinationally with RST so nothing is offered during reset.
    assign bus.in_ready   = (state_q == IDLE) && !RST;
    assign bus.unsync_bus = data_q;
    assign bus.bus_enable = en_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_data_sync_tx.sv
// tb_data_sync_tx
// Bench for data_sync_tx: default timing instance (4/4), a fast instance
// (1/1), and a slow-hold instance (12/4) feeding a behavioural receiver
// synchronizer on a 2.7x slower destination clock. With
// DATA_SYNC_TX_ACK_EN defined, the four-phase handshake is exercised.
module tb_data_sync_tx;

    logic clk     = 1'b0;
    logic clk_dst = 1'b0;
    logic RST     = 1'b1;

    always #10 clk = ~clk;
    always #27 clk_dst = ~clk_dst;

    data_sync_tx_if #(.BUS_WIDTH(8)) if0 ();
    data_sync_tx_if #(.BUS_WIDTH(8)) if1 ();
    data_sync_tx_if #(.BUS_WIDTH(8)) if2 ();

`ifdef DATA_SYNC_TX_ACK_EN
    logic bus_ack = 1'b0;
`endif

    data_sync_tx #(.BUS_WIDTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(4), .CNT_WIDTH(4)) dut0 (
        .CLK(clk), .RST(RST),
`ifdef DATA_SYNC_TX_ACK_EN
        .bus_ack(bus_ack),
`endif
        .bus(if0)
    );

    data_sync_tx #(.BUS_WIDTH(8), .HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_WIDTH(4)) dut1 (
        .CLK(clk), .RST(RST),
`ifdef DATA_SYNC_TX_ACK_EN
        .bus_ack(if1.bus_enable),
`endif
        .bus(if1)
    );

    data_sync_tx #(.BUS_WIDTH(8), .HOLD_CYCLES(12), .GAP_CYCLES(4), .CNT_WIDTH(4)) dut2 (
        .CLK(clk), .RST(RST),
`ifdef DATA_SYNC_TX_ACK_EN
        .bus_ack(if2.bus_enable),
`endif
        .bus(if2)
    );

    // Behavioural receive side: 2-stage enable sync, capture on rising edge.
    logic [1:0] rx_sync = 2'b00;
    logic       rx_prev = 1'b0;
    logic [7:0] rx_q[$];

    always @(posedge clk_dst) begin
        rx_sync <= {rx_sync[0], if2.bus_enable};
        rx_prev <= rx_sync[1];
        if (rx_sync[1] === 1'b1 && rx_prev === 1'b0) rx_q.push_back(if2.unsync_bus);
    end

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];

    initial begin
        if0.in_valid = 1'b0; if0.in_data = '0;
        if1.in_valid = 1'b0; if1.in_data = '0;
        if2.in_valid = 1'b0; if2.in_data = '0;
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic pop_check0(input string name);
        logic [7:0] e;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: got %h, scoreboard empty", name, if0.unsync_bus);
        end else begin
            e = exp_q.pop_front();
            if (if0.unsync_bus !== e) $display("FAIL %s: got %h expected %h", name, if0.unsync_bus, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset;
        repeat (3) step;
        total_cnt++;
        if ({if0.in_ready, if0.bus_enable, if0.busy, if0.unsync_bus} !== 11'd0)
            $display("FAIL reset_vals: got rdy=%b en=%b busy=%b bus=%h expected all 0",
                     if0.in_ready, if0.bus_enable, if0.busy, if0.unsync_bus);
        else pass_cnt++;
        total_cnt++;
        if ({if1.in_ready, if1.bus_enable, if2.in_ready, if2.bus_enable} !== 4'd0)
            $display("FAIL reset_vals_other: got %b expected 0000",
                     {if1.in_ready, if1.bus_enable, if2.in_ready, if2.bus_enable});
        else pass_cnt++;
        RST = 1'b0;
        #1;
        total_cnt++;
        if (if0.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", if0.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_single;
        step;
        total_cnt++;
        if (if0.in_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", if0.in_ready);
        else pass_cnt++;
        if0.in_data = 8'hA5; if0.in_valid = 1'b1; exp_q.push_back(8'hA5);
        step;
        if0.in_valid = 1'b0; if0.in_data = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) pop_check0("single_word");
            total_cnt++;
            if ({if0.bus_enable, if0.in_ready, if0.busy} !== 3'b101 || if0.unsync_bus !== 8'hA5)
                $display("FAIL single_hold[%0d]: got en=%b rdy=%b busy=%b bus=%h expected 1 0 1 a5",
                         i, if0.bus_enable, if0.in_ready, if0.busy, if0.unsync_bus);
            else pass_cnt++;
            step;
        end
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({if0.bus_enable, if0.in_ready, if0.busy} !== 3'b001 || if0.unsync_bus !== 8'hA5)
                $display("FAIL single_gap[%0d]: got en=%b rdy=%b busy=%b bus=%h expected 0 0 1 a5",
                         i, if0.bus_enable, if0.in_ready, if0.busy, if0.unsync_bus);
            else pass_cnt++;
            step;
        end
        total_cnt++;
        if ({if0.in_ready, if0.busy} !== 2'b10)
            $display("FAIL single_idle: got rdy=%b busy=%b expected 1 0", if0.in_ready, if0.busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int n_acc = 0;
        int n_pop = 0;
        int acc_cyc[2];
        logic prev_en = 1'b0;
        logic [7:0] prev_bus = '0;
        logic acc;
        if0.in_data = 8'h11; if0.in_valid = 1'b1;
        for (int c = 0; c < 40 && n_pop < 2; c++) begin
            if (if0.bus_enable === 1'b1 && prev_en === 1'b1) begin
                total_cnt++;
                if (if0.unsync_bus !== prev_bus)
                    $display("FAIL b2b_stable: got %h expected %h", if0.unsync_bus, prev_bus);
                else pass_cnt++;
            end
            if (if0.bus_enable === 1'b1 && prev_en === 1'b0) begin
                pop_check0("b2b_word");
                n_pop++;
            end
            acc = if0.in_ready && if0.in_valid;
            if (acc) begin
                acc_cyc[n_acc] = c;
                exp_q.push_back(if0.in_data);
                n_acc++;
            end
            prev_en = if0.bus_enable;
            prev_bus = if0.unsync_bus;
            step;
            if (acc) begin
                if (n_acc == 1) if0.in_data = 8'h22;
                else if0.in_valid = 1'b0;
            end
        end
        if0.in_valid = 1'b0;
        total_cnt++;
        if (n_pop != 2) $display("FAIL b2b_timeout: got %0d words expected 2", n_pop);
        else pass_cnt++;
        total_cnt++;
        if (n_acc != 2 || acc_cyc[1] - acc_cyc[0] != 9)
            $display("FAIL b2b_spacing: got %0d accepts spacing %0d expected 2 accepts spacing 9",
                     n_acc, (n_acc == 2) ? acc_cyc[1] - acc_cyc[0] : -1);
        else pass_cnt++;
        for (int t = 0; t < 30 && !if0.in_ready; t++) step;
    endtask

    task automatic test_reset_mid_hold;
        step;
        if0.in_data = 8'h5A; if0.in_valid = 1'b1; exp_q.push_back(8'h5A);
        step;
        if0.in_valid = 1'b0;
        pop_check0("rst_hold_word");
        step;
        total_cnt++;
        if (if0.bus_enable !== 1'b1) $display("FAIL rst_hold_en2: got %b expected 1", if0.bus_enable);
        else pass_cnt++;
        RST = 1'b1;
        #1;
        total_cnt++;
        if (if0.in_ready !== 1'b0) $display("FAIL rst_hold_ready_now: got %b expected 0", if0.in_ready);
        else pass_cnt++;
        step;
        total_cnt++;
        if ({if0.bus_enable, if0.busy, if0.in_ready} !== 3'b000 || if0.unsync_bus !== 8'h00)
            $display("FAIL rst_hold_after: got en=%b busy=%b rdy=%b bus=%h expected 0 0 0 00",
                     if0.bus_enable, if0.busy, if0.in_ready, if0.unsync_bus);
        else pass_cnt++;
        step;
        total_cnt++;
        if (if0.in_ready !== 1'b0) $display("FAIL rst_hold_ready_held: got %b expected 0", if0.in_ready);
        else pass_cnt++;
        RST = 1'b0;
        #1;
        total_cnt++;
        if (if0.in_ready !== 1'b1) $display("FAIL rst_hold_release: got %b expected 1", if0.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_fast;
        logic [7:0] words[3] = '{8'h01, 8'h02, 8'h03};
        logic [7:0] e;
        int idx = 1;
        step;
        total_cnt++;
        if (if1.in_ready !== 1'b1) $display("FAIL fast_ready0: got %b expected 1", if1.in_ready);
        else pass_cnt++;
        if1.in_data = words[0]; if1.in_valid = 1'b1; exp_q.push_back(words[0]);
        for (int c = 0; c < 9; c++) begin
            step;
            total_cnt++;
            if (if1.bus_enable !== (c % 3 == 0) || if1.in_ready !== (c % 3 == 2))
                $display("FAIL fast_pattern[%0d]: got en=%b rdy=%b expected en=%b rdy=%b",
                         c, if1.bus_enable, if1.in_ready, (c % 3 == 0), (c % 3 == 2));
            else pass_cnt++;
            if (if1.bus_enable === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL fast_word: got %h, scoreboard empty", if1.unsync_bus);
                end else begin
                    e = exp_q.pop_front();
                    if (if1.unsync_bus !== e) $display("FAIL fast_word: got %h expected %h", if1.unsync_bus, e);
                    else pass_cnt++;
                end
            end
            if (c % 3 == 0) begin
                if (idx < 3) begin
                    if1.in_data = $urandom_range(0, 255);
                end else begin
                    if1.in_valid = 1'b0;
                end
            end
            if (if1.in_ready === 1'b1 && idx < 3) begin
                if1.in_data = words[idx]; exp_q.push_back(words[idx]); idx++;
            end
        end
        if1.in_valid = 1'b0;
    endtask

    task automatic test_end_to_end;
        logic [7:0] w, e, r;
        int t;
        rx_q.delete();
        for (int n = 0; n < 20; n++) begin
            t = 0;
            while (!if2.in_ready && t < 50) begin step; t++; end
            if (t == 50) begin
                total_cnt++;
                $display("FAIL e2e_ready_timeout: got in_ready=0 expected 1 within 50 cycles");
            end
            w = 8'($urandom_range(0, 255));
            if2.in_data = w; if2.in_valid = 1'b1; exp2_q.push_back(w);
            step;
            if2.in_valid = 1'b0;
            if2.in_data = 8'($urandom_range(0, 255));
        end
        t = 0;
        while (rx_q.size() < 20 && t < 1000) begin step; t++; end
        repeat (100) step;
        total_cnt++;
        if (rx_q.size() != 20) $display("FAIL e2e_count: got %0d pulses expected 20", rx_q.size());
        else pass_cnt++;
        for (int n = 0; n < 20; n++) begin
            total_cnt++;
            if (rx_q.size() == 0 || exp2_q.size() == 0) begin
                $display("FAIL e2e_word[%0d]: got missing entry expected data", n);
            end else begin
                r = rx_q.pop_front();
                e = exp2_q.pop_front();
                if (r !== e) $display("FAIL e2e_word[%0d]: got %h expected %h", n, r, e);
                else pass_cnt++;
            end
        end
    endtask

`ifdef DATA_SYNC_TX_ACK_EN
    task automatic test_ack;
        step;
        if0.in_data = 8'hC3; if0.in_valid = 1'b1; exp_q.push_back(8'hC3);
        step;
        if0.in_valid = 1'b0;
        pop_check0("ack_word");
        for (int i = 0; i < 10; i++) begin
            total_cnt++;
            if (if0.bus_enable !== 1'b1) $display("FAIL ack_hold[%0d]: got %b expected 1", i, if0.bus_enable);
            else pass_cnt++;
            step;
        end
        bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            total_cnt++;
            if (if0.bus_enable !== (i < 2)) $display("FAIL ack_release[%0d]: got %b expected %b", i, if0.bus_enable, (i < 2));
            else pass_cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            step;
            total_cnt++;
            if ({if0.bus_enable, if0.in_ready, if0.busy} !== 3'b001)
                $display("FAIL ack_gap[%0d]: got en=%b rdy=%b busy=%b expected 0 0 1",
                         i, if0.bus_enable, if0.in_ready, if0.busy);
            else pass_cnt++;
        end
        bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            total_cnt++;
            if (if0.in_ready !== (i == 2)) $display("FAIL ack_gap_exit[%0d]: got %b expected %b", i, if0.in_ready, (i == 2));
            else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset;
`ifdef DATA_SYNC_TX_ACK_EN
        test_ack;
`else
        test_single;
        test_back_to_back;
        test_reset_mid_hold;
        test_fast;
        test_end_to_end;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
